// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB command master.
// Holds the data width, FSM state encoding and register map.
package uart_apb_pkg;

  localparam int BITWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_BAUD = 2'd0;
  localparam logic [1:0] ADDR_PREC = 2'd1;
  localparam logic [1:0] ADDR_DATA = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Command queue: registered occupancy, full/empty from count.
// Pointers wrap modulo DEPTH.
module uart_cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/uart_apb_master.sv
// Drains queued register commands onto APB, one transfer at a time.
// Reports each completion or PREADY timeout as a one-cycle response.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int BITWIDTH   = uart_apb_pkg::BITWIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                i_pclk,
  input  logic                i_presetn,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [1:0]          i_cmd_addr,
  input  logic [BITWIDTH-1:0] i_cmd_wdata,
  output logic                o_rsp_valid,
  output logic [BITWIDTH-1:0] o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_psel,
  output logic                o_penable,
  output logic                o_pwrite,
  output logic [1:0]          o_paddr,
  output logic [BITWIDTH-1:0] o_pwdata,
  input  logic [BITWIDTH-1:0] i_prdata,
  input  logic                i_pready
);

  localparam int CW = BITWIDTH + 3;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [CW-1:0]       w_fifo_dout;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_done;
  logic                w_tout;

  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [1:0]          r_paddr;
  logic [BITWIDTH-1:0] r_pwdata;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [BITWIDTH-1:0] r_rsp_rdata;
  logic [WAIT_W-1:0]   r_wait;

  logic                w_psel_n;
  logic                w_penable_n;
  logic                w_rsp_valid_n;
  logic                w_rsp_err_n;
  logic [BITWIDTH-1:0] w_rsp_rdata_n;

  uart_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_pclk),
    .i_rst_n (i_presetn),
    .i_push  (i_cmd_valid),
    .i_din   ({i_cmd_write, i_cmd_addr, i_cmd_wdata}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_cmd_ready = ~w_full;

  assign w_done = (r_state == ACCESS) & i_pready;
  assign w_tout = (r_state == ACCESS) & ~i_pready
                & (r_wait == WAIT_LAST);
  // Pop from IDLE, or chain straight into the next SETUP on completion.
  assign w_pop = ~w_empty & ((r_state == IDLE) | w_done);

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS: begin
        if (i_pready)
          w_state_nxt = w_empty ? IDLE : SETUP;
        else if (w_tout)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_psel_n      = r_psel;
    w_penable_n   = r_penable;
    w_rsp_valid_n = 1'b0;
    w_rsp_err_n   = 1'b0;
    w_rsp_rdata_n = '0;
    unique case (r_state)
      IDLE: begin
        w_psel_n    = ~w_empty;
        w_penable_n = 1'b0;
      end
      SETUP: w_penable_n = 1'b1;
      ACCESS: begin
        if (i_pready) begin
          w_rsp_valid_n = 1'b1;
          w_rsp_rdata_n = r_pwrite ? '0 : i_prdata;
          w_psel_n      = ~w_empty;
          w_penable_n   = 1'b0;
        end else if (w_tout) begin
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b1;
          w_psel_n      = 1'b0;
          w_penable_n   = 1'b0;
        end
      end
      default: begin
        w_psel_n    = 1'b0;
        w_penable_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_wait      <= '0;
    end else begin
      r_psel      <= w_psel_n;
      r_penable   <= w_penable_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_err   <= w_rsp_err_n;
      r_rsp_rdata <= w_rsp_rdata_n;
      if (w_pop)
        {r_pwrite, r_paddr, r_pwdata} <= w_fifo_dout;
      if (w_pop)
        r_wait <= '0;
      else if ((r_state == ACCESS) && !i_pready && !w_tout)
        r_wait <= r_wait + 1'b1;
    end
  end

  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: latency, back-to-back,
// wait states, timeout and mid-transfer reset.
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;

  int total = 0;
  int bad   = 0;

  uart_apb_master dut (
    .i_pclk      (clk),
    .i_presetn   (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .i_prdata    (prdata),
    .i_pready    (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic w,
                      input logic [1:0] a,
                      input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] ea [4];
    logic [7:0] ed [4];
    int cnt;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 2'd0;
    cmd_wdata = 8'h00;
    prdata    = 8'h00;
    pready    = 1'b1;

    // reset state
    tick();
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", 32'(pwdata), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // single write, latency N+1/N+2/N+3
    push(1'b1, ADDR_BAUD, 8'h0D);
    chk("lat_n_psel", 32'(psel), 0);
    chk("lat_n_ready", 32'(cmd_ready), 1);
    tick();
    chk("lat_n1_psel", 32'(psel), 1);
    chk("lat_n1_pen", 32'(penable), 0);
    chk("lat_n1_paddr", 32'(paddr), 0);
    chk("lat_n1_pwdata", 32'(pwdata), 32'h0D);
    chk("lat_n1_pwrite", 32'(pwrite), 1);
    tick();
    chk("lat_n2_pen", 32'(penable), 1);
    chk("lat_n2_psel", 32'(psel), 1);
    chk("lat_n2_rsp", 32'(rsp_valid), 0);
    tick();
    chk("lat_n3_rsp", 32'(rsp_valid), 1);
    chk("lat_n3_err", 32'(rsp_err), 0);
    chk("lat_n3_rdata", 32'(rsp_rdata), 0);
    chk("lat_n3_psel", 32'(psel), 0);
    chk("lat_n3_pen", 32'(penable), 0);
    tick();
    chk("lat_n4_rsp", 32'(rsp_valid), 0);
    chk("idle_paddr_hold", 32'(paddr), 0);
    chk("idle_pwdata_hold", 32'(pwdata), 32'h0D);

    // read with 3 wait states
    pready = 1'b0;
    prdata = 8'h9A;
    push(1'b0, ADDR_DATA, 8'h00);
    tick();
    chk("rd_setup_psel", 32'(psel), 1);
    chk("rd_setup_paddr", 32'(paddr), 2);
    chk("rd_setup_pwrite", 32'(pwrite), 0);
    tick();
    chk("rd_pen_1", 32'(penable), 1);
    tick();
    chk("rd_pen_2", 32'(penable), 1);
    chk("rd_wait_rsp", 32'(rsp_valid), 0);
    tick();
    chk("rd_pen_3", 32'(penable), 1);
    tick();
    chk("rd_pen_4", 32'(penable), 1);
    chk("rd_wait_rsp2", 32'(rsp_valid), 0);
    pready = 1'b1;
    tick();
    chk("rd_rsp", 32'(rsp_valid), 1);
    chk("rd_rdata", 32'(rsp_rdata), 32'h9A);
    chk("rd_err", 32'(rsp_err), 0);
    chk("rd_pen_off", 32'(penable), 0);
    tick();

    // queue fills behind a stalled read, then drains back-to-back
    pready = 1'b0;
    prdata = 8'h55;
    push(1'b0, ADDR_CTRL, 8'h00);
    push(1'b1, ADDR_BAUD, 8'h0D);
    push(1'b1, ADDR_PREC, 8'h00);
    push(1'b1, ADDR_DATA, 8'h9A);
    push(1'b1, ADDR_CTRL, 8'h00);
    chk("full_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = ADDR_BAUD;
    cmd_wdata = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    chk("full_ready_hold", 32'(cmd_ready), 0);
    pready = 1'b1;
    tick();
    chk("stall_rsp", 32'(rsp_valid), 1);
    chk("stall_rdata", 32'(rsp_rdata), 32'h55);
    chk("pop_ready", 32'(cmd_ready), 1);
    ea[0] = ADDR_BAUD; ed[0] = 8'h0D;
    ea[1] = ADDR_PREC; ed[1] = 8'h00;
    ea[2] = ADDR_DATA; ed[2] = 8'h9A;
    ea[3] = ADDR_CTRL; ed[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b%0d_psel", k), 32'(psel), 1);
      chk($sformatf("b2b%0d_pen", k), 32'(penable), 0);
      chk($sformatf("b2b%0d_paddr", k), 32'(paddr), 32'(ea[k]));
      chk($sformatf("b2b%0d_pwdata", k), 32'(pwdata), 32'(ed[k]));
      tick();
      chk($sformatf("b2b%0d_access", k), 32'(penable), 1);
      tick();
      chk($sformatf("b2b%0d_rsp", k), 32'(rsp_valid), 1);
      chk($sformatf("b2b%0d_rdata", k), 32'(rsp_rdata), 0);
    end
    chk("b2b_end_psel", 32'(psel), 0);
    tick();
    chk("b2b_no_extra", 32'(psel), 0);
    tick();

    // timeout followed by the next queued command
    pready = 1'b0;
    push(1'b1, ADDR_DATA, 8'h77);
    push(1'b1, ADDR_PREC, 8'h33);
    cnt = 0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      if (penable) cnt++;
      tick();
    end
    chk("to_seen", 32'(rsp_valid), 1);
    chk("to_cycles", 32'(cnt), 16);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_rdata", 32'(rsp_rdata), 0);
    chk("to_psel", 32'(psel), 0);
    chk("to_pen", 32'(penable), 0);
    pready = 1'b1;
    tick();
    chk("to_next_psel", 32'(psel), 1);
    chk("to_next_paddr", 32'(paddr), 1);
    chk("to_next_pwdata", 32'(pwdata), 32'h33);
    chk("to_next_rsp", 32'(rsp_valid), 0);
    tick();
    tick();
    chk("to_next_done", 32'(rsp_valid), 1);
    chk("to_next_err", 32'(rsp_err), 0);
    tick();

    // reset during ACCESS with two queued
    pready = 1'b0;
    push(1'b1, ADDR_BAUD, 8'h11);
    push(1'b1, ADDR_PREC, 8'h22);
    push(1'b1, ADDR_DATA, 8'h33);
    chk("mr_access", 32'(penable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_psel", 32'(psel), 0);
    chk("mr_pen", 32'(penable), 0);
    chk("mr_paddr", 32'(paddr), 0);
    chk("mr_pwdata", 32'(pwdata), 0);
    chk("mr_pwrite", 32'(pwrite), 0);
    chk("mr_rsp", 32'(rsp_valid), 0);
    chk("mr_ready", 32'(cmd_ready), 1);
    tick();
    tick();
    rst_n  = 1'b1;
    pready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || psel) cnt++;
    end
    chk("mr_quiet", 32'(cnt), 0);
    chk("mr_ready_after", 32'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 Parameter BITWIDTH, default 8, sets the width of the APB data bus and the command data.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the number of command-queue entries (power of two).
REQ-003 Parameter TIMEOUT, default 16, sets the maximum number of ACCESS cycles to wait for PREADY.
REQ-004 PCLK  in  1  single clock; all logic on rising edge.
REQ-005 PRESETN  in  1  reset, asynchronous, active-low.
REQ-006 CMD_VALID  in  1  command present.
REQ-007 CMD_READY  out  1  queue can accept a command.
REQ-008 CMD_WRITE  in  1  1 = APB write, 0 = APB read.
REQ-009 CMD_ADDR  in  2  target register: 0 = baud value, 1 = precision, 2 = data, 3 = control.
REQ-010 CMD_WDATA  in  BITWIDTH  write data.
REQ-011 RSP_VALID  out  1  one-cycle completion pulse.
REQ-012 RSP_RDATA  out  BITWIDTH  captured PRDATA for reads, 0 for writes and errors.
REQ-013 RSP_ERR  out  1  qualified by RSP_VALID; 1 = timeout abort.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-015 PADDR  out  2  APB address.
REQ-016 PWDATA  out  BITWIDTH  APB write data.
REQ-017 PRDATA  in  BITWIDTH  APB read data.
REQ-018 PREADY  in  1  APB slave ready.

Function
REQ-019 A command SHALL be pushed at the rising edge where CMD_VALID and CMD_READY are both 1.
REQ-020 CMD_READY SHALL equal NOT full, computed from registered occupancy; a same-cycle pop SHALL NOT enable a push into a full queue.
REQ-021 The FSM SHALL have three states, IDLE, SETUP and ACCESS, with IDLE as the reset state.
REQ-022 In IDLE with a non-empty queue, the block SHALL pop one entry, load PADDR/PWDATA/PWRITE, set PSEL=1 and PENABLE=0, then enter SETUP.
REQ-023 In IDLE with an empty queue, PSEL and PENABLE SHALL be 0 and no transfer SHALL start.
REQ-024 SETUP SHALL last exactly one cycle, then the block SHALL enter ACCESS with PENABLE=1.
REQ-025 In ACCESS with PREADY=1, the transfer SHALL complete: RSP_VALID=1 for one cycle, RSP_ERR=0, and RSP_RDATA=PRDATA (read) or 0 (write).
REQ-026 On completion with a non-empty queue, the block SHALL go directly to SETUP with the next entry (PSEL held 1, PENABLE 0); otherwise it SHALL go to IDLE with PSEL=0 and PENABLE=0.
REQ-027 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP until completion, and SHALL retain their last values while in IDLE.
REQ-028 A wait counter SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT the block SHALL abort with RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0, then go to IDLE.
REQ-029 The wait counter SHALL clear on every SETUP entry.
REQ-030 Latency: for a push at edge N into an empty queue while IDLE with PREADY=1, PSEL SHALL rise after edge N+1, PENABLE after N+2, and RSP_VALID SHALL be high in the cycle after N+3.
REQ-031 Commands SHALL be issued strictly in FIFO order, one outstanding transfer at a time.
REQ-032 A push and a pop in the same cycle on a non-full, non-empty queue SHALL leave occupancy unchanged.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 PRESETN=0 SHALL immediately clear state to IDLE and set PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_RDATA, RSP_ERR and the wait counter to 0.
REQ-035 PRESETN=0 SHALL empty the queue, so CMD_READY=1 while in reset.
REQ-036 A reset asserted mid-transfer SHALL abandon the transfer with no RSP_VALID; queued commands SHALL be discarded.

Structure
REQ-037 A shared package uart_apb_pkg SHALL hold BITWIDTH, the state enum (IDLE, SETUP, ACCESS) and address constants ADDR_BAUD=0, ADDR_PREC=1, ADDR_DATA=2, ADDR_CTRL=3.
REQ-038 The command queue SHALL be the sub-module uart_cmd_fifo, of width 1+2+BITWIDTH, with push/pop/full/empty ports.

Verification
REQ-039 Write 0x0D to addr 0 with PREADY=1 -> PSEL/PENABLE timing per REQ-030, PWDATA=0x0D, PADDR=0, then RSP_VALID=1, RSP_ERR=0.
REQ-040 Push writes 0x0D@0, 0x00@1, 0x9A@2, 0x00@3 back-to-back -> four in-order transfers with no IDLE between them, CMD_READY=0 after the 4th push until the first pop.
REQ-041 Read addr 2 with slave PRDATA=0x9A and PREADY held 0 for 3 cycles -> PENABLE held for 4 cycles, RSP_RDATA=0x9A.
REQ-042 Write with PREADY stuck at 0 -> after 16 ACCESS cycles RSP_VALID=1, RSP_ERR=1, FSM returns to IDLE, and the next queued command proceeds.
REQ-043 PRESETN low during ACCESS with 2 entries queued -> outputs 0 asynchronously, no RSP_VALID, queue empty and CMD_READY=1 after release.
